// File: rtl/ram_if_pkg.sv
// Shared definitions for the RAM request interface.
// Holds the copy-engine FSM state encoding and the default data and address
// widths, which the RAM uses as well.
package ram_if_pkg;

    localparam int DWIDTH_DEF = 16;
    localparam int AWIDTH_DEF = 16;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RD_REQ  = 3'd1;
    localparam logic [2:0] ST_RD_WAIT = 3'd2;
    localparam logic [2:0] ST_WR_REQ  = 3'd3;
    localparam logic [2:0] ST_WR_WAIT = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;

endpackage

// File: rtl/ram_copy_engine_wait_timer.sv
// wait_timer: a loadable down-counter that times one RAM request.
//   clk, rst : clock and synchronous active-high reset
//   load     : loads load_val; it has priority over counting
//   load_val : starting count
//   expired  : high while the count is zero
// When load is low the counter decrements and stops at zero.
module wait_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             expired
);

    logic [WIDTH-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/ram_copy_engine.sv
// ram_copy_engine: copies len_i words from src_addr_i to dst_addr_i.
// It issues one single-word read, then one single-word write, and waits for
// ram_valid after each request.
//   start_i, src_addr_i, dst_addr_i, len_i : launch a copy (sampled in IDLE only)
//   busy_o, done_o, err_o, words_o         : status (err_o is a sticky timeout)
//   ram_en, wen, addr_o, w_data_o          : RAM request, registered
//   r_data_i, ram_valid                    : RAM response
module ram_copy_engine
    import ram_if_pkg::*;
#(
    parameter int DWIDTH  = DWIDTH_DEF,
    parameter int AWIDTH  = AWIDTH_DEF,
    parameter int LWIDTH  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [AWIDTH-1:0] src_addr_i,
    input  logic [AWIDTH-1:0] dst_addr_i,
    input  logic [LWIDTH-1:0] len_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [LWIDTH-1:0] words_o,
    output logic              ram_en,
    output logic              wen,
    output logic [AWIDTH-1:0] addr_o,
    output logic [DWIDTH-1:0] w_data_o,
    input  logic [DWIDTH-1:0] r_data_i,
    input  logic              ram_valid
);

    localparam int TW = $clog2(TIMEOUT + 1);

    logic [2:0]        state;
    logic [AWIDTH-1:0] src_q, dst_q;
    logic [LWIDTH-1:0] len_q;
    logic              tmr_load, tmr_expired;

    // The timer is loaded during each REQ cycle, so the count is fresh on
    // the first cycle of the following wait state. It reads zero after
    // TIMEOUT wait cycles.
    assign tmr_load = (state == ST_RD_REQ) || (state == ST_WR_REQ);

    wait_timer #(.WIDTH(TW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (TW'(TIMEOUT - 1)),
        .expired  (tmr_expired)
    );

    assign busy_o = (state != ST_IDLE);

    // The request outputs are set on the transition into a REQ state, so
    // ram_en is high for exactly the REQ cycle. w_data_o also serves as the
    // data register between the read and the write.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            src_q    <= '0;
            dst_q    <= '0;
            len_q    <= '0;
            done_o   <= 1'b0;
            err_o    <= 1'b0;
            words_o  <= '0;
            ram_en   <= 1'b0;
            wen      <= 1'b0;
            addr_o   <= '0;
            w_data_o <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done_o <= 1'b0;
                    if (start_i) begin
                        src_q   <= src_addr_i;
                        dst_q   <= dst_addr_i;
                        len_q   <= len_i;
                        words_o <= '0;
                        err_o   <= 1'b0;
                        if (len_i == '0) begin
                            state <= ST_DONE;
                        end else begin
                            state  <= ST_RD_REQ;
                            ram_en <= 1'b1;
                            wen    <= 1'b0;
                            addr_o <= src_addr_i;
                        end
                    end
                end
                ST_RD_REQ: begin
                    ram_en <= 1'b0;
                    state  <= ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    if (ram_valid) begin
                        w_data_o <= r_data_i;
                        state    <= ST_WR_REQ;
                        ram_en   <= 1'b1;
                        wen      <= 1'b1;
                        addr_o   <= dst_q;
                    end else if (tmr_expired) begin
                        err_o  <= 1'b1;
                        done_o <= 1'b1;
                        state  <= ST_DONE;
                    end
                end
                ST_WR_REQ: begin
                    ram_en <= 1'b0;
                    state  <= ST_WR_WAIT;
                end
                ST_WR_WAIT: begin
                    if (ram_valid) begin
                        src_q   <= src_q + 1'b1;
                        dst_q   <= dst_q + 1'b1;
                        words_o <= words_o + 1'b1;
                        if (words_o + LWIDTH'(1) == len_q) begin
                            done_o <= 1'b1;
                            state  <= ST_DONE;
                        end else begin
                            state  <= ST_RD_REQ;
                            ram_en <= 1'b1;
                            wen    <= 1'b0;
                            addr_o <= src_q + 1'b1;
                        end
                    end else if (tmr_expired) begin
                        err_o  <= 1'b1;
                        done_o <= 1'b1;
                        state  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // Wait states raise done_o on the way in. A zero-length
                    // start arrives with done_o low and spends one padding
                    // cycle here, which gives it the same two-cycle latency
                    // as the handshake path.
                    if (done_o) begin
                        done_o <= 1'b0;
                        state  <= ST_IDLE;
                    end else begin
                        done_o <= 1'b1;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    done_o <= 1'b0;
                    ram_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_copy_engine.sv
module tb_ram_copy_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic [15:0] src_addr_i = '0, dst_addr_i = '0, len_i = '0;
    logic        busy_o, done_o, err_o;
    logic [15:0] words_o;
    logic        ram_en, wen;
    logic [15:0] addr_o, w_data_o;
    logic [15:0] r_data_i = '0;
    logic        ram_valid = 1'b0;

    ram_copy_engine #(.DWIDTH(16), .AWIDTH(16), .LWIDTH(16), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .src_addr_i(src_addr_i),
        .dst_addr_i(dst_addr_i), .len_i(len_i), .busy_o(busy_o), .done_o(done_o),
        .err_o(err_o), .words_o(words_o), .ram_en(ram_en), .wen(wen),
        .addr_o(addr_o), .w_data_o(w_data_o), .r_data_i(r_data_i),
        .ram_valid(ram_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // One-cycle RAM model. The request whose index equals stall_at gets no response.
    logic [15:0] mem [0:65535];
    logic        pl_en = 1'b0;
    logic [15:0] pl_addr = '0, pl_data = '0;
    int          req_cnt = 0;
    int          stall_at = -1;

    always @(posedge clk) begin
        ram_valid <= 1'b0;
        if (pl_en) mem[pl_addr] <= pl_data;
        if (ram_en) begin
            req_cnt <= req_cnt + 1;
            if (req_cnt != stall_at) begin
                ram_valid <= 1'b1;
                if (wen) mem[addr_o] <= w_data_o;
                else     r_data_i <= mem[addr_o];
            end
        end
    end

    typedef struct { logic w; logic [15:0] a; logic [15:0] d; } req_t;
    typedef struct { int sc; int lat; logic [15:0] words; logic err; } done_t;
    req_t  req_q[$];
    done_t done_q[$];

    int total = 0, bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the expectation queues whenever the DUT issues a request or pulses done.
    logic prev_en = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            prev_en <= 1'b0;
        end else begin
            if (ram_en) begin
                chk("ram_en_back_to_back", {31'd0, prev_en}, 32'd0);
                if (req_q.size() == 0) begin
                    chk("unexpected_request", 32'd1, 32'd0);
                end else begin
                    req_t r;
                    r = req_q.pop_front();
                    chk("req_wen", {31'd0, wen}, {31'd0, r.w});
                    chk("req_addr", {16'd0, addr_o}, {16'd0, r.a});
                    if (r.w) chk("req_wdata", {16'd0, w_data_o}, {16'd0, r.d});
                end
            end
            prev_en <= ram_en;
            if (done_o) begin
                if (done_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    done_t e;
                    e = done_q.pop_front();
                    chk("done_latency", cyc - e.sc, e.lat);
                    chk("done_words", {16'd0, words_o}, {16'd0, e.words});
                    chk("done_err", {31'd0, err_o}, {31'd0, e.err});
                    chk("done_busy", {31'd0, busy_o}, 32'd1);
                end
            end
        end
    end

    task automatic preload(input logic [15:0] a, input logic [15:0] d);
        @(posedge clk); #1;
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    task automatic push_req(input logic w, input logic [15:0] a, input logic [15:0] d);
        req_t r;
        r.w = w; r.a = a; r.d = d;
        req_q.push_back(r);
    endtask

    task automatic start_xfer(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l,
                              input int lat, input logic [15:0] w, input logic e);
        done_t x;
        @(posedge clk); #1;
        src_addr_i = s; dst_addr_i = d; len_i = l; start_i = 1'b1;
        x.sc = cyc; x.lat = lat; x.words = w; x.err = e;
        done_q.push_back(x);
        @(posedge clk); #1;
        start_i = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while ((done_q.size() != 0 || busy_o) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 300) chk("wait_done_timeout", 32'd1, 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
        chk({tag, "_done"}, {31'd0, done_o}, 32'd0);
        chk({tag, "_err"}, {31'd0, err_o}, 32'd0);
        chk({tag, "_words"}, {16'd0, words_o}, 32'd0);
        chk({tag, "_ram_en"}, {31'd0, ram_en}, 32'd0);
        chk({tag, "_wen"}, {31'd0, wen}, 32'd0);
        chk({tag, "_addr"}, {16'd0, addr_o}, 32'd0);
        chk({tag, "_wdata"}, {16'd0, w_data_o}, 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk_outputs_zero("reset");
        rst = 1'b0;

        // Basic copy: 4 words, 0x10 -> 0x100.
        for (int i = 0; i < 4; i++) preload(16'h0010 + 16'(i), 16'hA000 + 16'(i));
        for (int i = 0; i < 4; i++) begin
            push_req(1'b0, 16'h0010 + 16'(i), 16'h0);
            push_req(1'b1, 16'h0100 + 16'(i), 16'hA000 + 16'(i));
        end
        start_xfer(16'h0010, 16'h0100, 16'd4, 17, 16'd4, 1'b0);
        wait_done();
        for (int i = 0; i < 4; i++) chk("basic_mem", {16'd0, mem[16'h0100 + 16'(i)]}, {16'd0, 16'hA000 + 16'(i)});

        // Zero length: no requests are expected, so any request is flagged by the monitor.
        start_xfer(16'h0500, 16'h0600, 16'd0, 2, 16'd0, 1'b0);
        wait_done();

        // Address wrap.
        preload(16'hFFFE, 16'hB000);
        preload(16'hFFFF, 16'hB001);
        preload(16'h0000, 16'hB002);
        push_req(1'b0, 16'hFFFE, 16'h0); push_req(1'b1, 16'h7FFF, 16'hB000);
        push_req(1'b0, 16'hFFFF, 16'h0); push_req(1'b1, 16'h8000, 16'hB001);
        push_req(1'b0, 16'h0000, 16'h0); push_req(1'b1, 16'h8001, 16'hB002);
        start_xfer(16'hFFFE, 16'h7FFF, 16'd3, 13, 16'd3, 1'b0);
        wait_done();
        chk("wrap_mem0", {16'd0, mem[16'h7FFF]}, 32'hB000);
        chk("wrap_mem2", {16'd0, mem[16'h8001]}, 32'hB002);

        // Timeout on the second write: 8 cycles for the first word and its re-read,
        // 15 wait cycles, then DONE.
        preload(16'h0200, 16'hC000);
        preload(16'h0201, 16'hC001);
        push_req(1'b0, 16'h0200, 16'h0); push_req(1'b1, 16'h0300, 16'hC000);
        push_req(1'b0, 16'h0201, 16'h0); push_req(1'b1, 16'h0301, 16'hC001);
        stall_at = req_cnt + 3;
        start_xfer(16'h0200, 16'h0300, 16'd5, 23, 16'd1, 1'b1);
        wait_done();
        chk("timeout_err_sticky", {31'd0, err_o}, 32'd1);
        stall_at = -1;
        preload(16'h0210, 16'hC100);
        push_req(1'b0, 16'h0210, 16'h0); push_req(1'b1, 16'h0310, 16'hC100);
        start_xfer(16'h0210, 16'h0310, 16'd1, 5, 16'd1, 1'b0);
        wait_done();
        chk("err_cleared", {31'd0, err_o}, 32'd0);

        // A start pulse during a transfer is ignored.
        preload(16'h0030, 16'hD000);
        preload(16'h0031, 16'hD001);
        push_req(1'b0, 16'h0030, 16'h0); push_req(1'b1, 16'h0130, 16'hD000);
        push_req(1'b0, 16'h0031, 16'h0); push_req(1'b1, 16'h0131, 16'hD001);
        start_xfer(16'h0030, 16'h0130, 16'd2, 9, 16'd2, 1'b0);
        @(posedge clk); #1;
        src_addr_i = 16'h0999; dst_addr_i = 16'h0888; len_i = 16'd7; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        wait_done();
        chk("busy_mem1", {16'd0, mem[16'h0131]}, 32'hD001);

        // Overlapping copy with dst > src replicates the first word.
        preload(16'h0020, 16'h1111);
        preload(16'h0021, 16'h2222);
        preload(16'h0022, 16'h3333);
        preload(16'h0023, 16'h4444);
        for (int i = 0; i < 3; i++) begin
            push_req(1'b0, 16'h0020 + 16'(i), 16'h0);
            push_req(1'b1, 16'h0021 + 16'(i), 16'h1111);
        end
        start_xfer(16'h0020, 16'h0021, 16'd3, 13, 16'd3, 1'b0);
        wait_done();
        for (int i = 1; i < 4; i++) chk("overlap_mem", {16'd0, mem[16'h0020 + 16'(i)]}, 32'h1111);

        // Reset during WR_WAIT of the first word.
        preload(16'h0040, 16'hE000);
        push_req(1'b0, 16'h0040, 16'h0); push_req(1'b1, 16'h0050, 16'hE000);
        begin
            done_t x;
            @(posedge clk); #1;
            src_addr_i = 16'h0040; dst_addr_i = 16'h0050; len_i = 16'd2; start_i = 1'b1;
            @(posedge clk); #1;
            start_i = 1'b0;
            begin
                int n = 0;
                while (!(ram_en && wen) && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                if (n >= 50) chk("reset_wait_wreq", 32'd1, 32'd0);
            end
            @(posedge clk); #1;
            rst = 1'b1;
            @(posedge clk); #1;
            chk_outputs_zero("midreset");
            rst = 1'b0;
            x.sc = 0;
            repeat (4) begin
                @(posedge clk); #1;
                chk("midreset_no_done", {31'd0, done_o}, 32'd0);
            end
        end
        push_req(1'b0, 16'h0040, 16'h0); push_req(1'b1, 16'h0060, 16'hE000);
        start_xfer(16'h0040, 16'h0060, 16'd1, 5, 16'd1, 1'b0);
        wait_done();
        chk("post_reset_mem", {16'd0, mem[16'h0060]}, 32'hE000);

        chk("req_queue_drained", req_q.size(), 32'd0);
        chk("done_queue_drained", done_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
